weight_bram_reader: RTL
=======================

Name: weight_bram_reader

Overview:
- Initiator-side controller for one weight BRAM port (ADDR/DI/EN/WE/DO; BRAM acts on the negedge of CLK).
- Read mode: sweeps addresses 0..DEPTH-1 and streams the 16-bit weights to a downstream MAC over valid/ready, with backpressure.
- Load mode: accepts a weight stream and writes it into the BRAM at addresses 0..DEPTH-1.
- Sits between the layer sequencer and each per-neuron weight BRAM.

Parameters:
- DATA_W, 16, weight width (matches BRAM DI/DO).
- ADDR_W, 5, BRAM address width.
- DEPTH, 28, number of weights per BRAM. Must be ≤ 2**ADDR_W.

Ports:
- CLK  in  1  system clock; all controller logic is on the posedge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse: begin read sweep.
- ld_start  in  1  1-cycle pulse: begin load sweep.
- busy  out  1  high while not IDLE.
- done  out  1  1-cycle pulse at the end of a sweep.
- ADDR  out  ADDR_W  BRAM address.
- DI  out  DATA_W  BRAM write data.
- EN  out  1  BRAM enable.
- WE  out  1  BRAM write enable.
- DO  in  DATA_W  BRAM read data.
- w_data  out  DATA_W  streamed weight.
- w_valid  out  1  w_data valid.
- w_ready  in  1  downstream accepts.
- w_last  out  1  marks the weight from address DEPTH-1.
- ld_data  in  DATA_W  weight to store.
- ld_valid  in  1  ld_data valid.
- ld_ready  out  1  controller accepts ld_data.

Behaviour:
- Reset values (asynchronous): ADDR=0, DI=0, EN=0, WE=0, busy=0, done=0, w_valid=0, w_last=0, w_data=0, ld_ready=0. FIFO is emptied, all pointers are cleared, state is IDLE.
- Reset mid-sweep: the sweep is aborted with no done pulse; EN and WE drop immediately.
- States: IDLE, READ, DRAIN, LOAD, FIN.
- IDLE transitions:
  - start → READ.
  - ld_start → LOAD.
  - start and ld_start in the same cycle → READ; ld_start is dropped.
  - start or ld_start while busy → ignored.
- BRAM timing: EN, WE, ADDR and DI are registered on the posedge. The BRAM samples them at the following negedge. For a read, DO is captured at the next posedge, so read latency is 1 cycle from issue to capture.
- EN is high only in cycles that issue a request, one request per cycle.
- In READ mode, WE=0.
- READ credit rule:
  - Output FIFO is 2 entries deep (skid buffer).
  - Issue a read at rd_addr only if fifo_count + inflight < 2. inflight is 0 or 1.
  - rd_addr increments after each issue.
  - After issuing address DEPTH-1, go to DRAIN.
- Capture: the cycle after an issue, push {DO, last=(addr==DEPTH-1)} into the FIFO.
- Stream side:
  - w_valid = FIFO non-empty. w_data and w_last come from the FIFO head.
  - Pop when w_valid && w_ready.
  - Push and pop in the same cycle is legal; count is unchanged.
  - w_data and w_last hold stable while w_valid && !w_ready.
- Throughput: with w_ready held high, one weight per cycle. The first w_valid appears 2 cycles after start (issue, capture).
- DRAIN: wait until inflight=0 and FIFO is empty (the last beat has been popped), then go to FIN.
- LOAD:
  - ld_ready=1.
  - Each cycle with ld_valid && ld_ready registers EN=1, WE=1, ADDR=wr_addr, DI=ld_data; wr_addr then increments.
  - When wr_addr reaches DEPTH: ld_ready=0, go to FIN.
  - Cycles with ld_valid=0 give EN=0.
- FIN: done=1 for one cycle, then IDLE. busy is low from the IDLE cycle onward.
- Addresses never exceed DEPTH-1; there is no wrap-around within a sweep. A new sweep always starts at 0.

Decomposition:
- Shared package: DATA_W, ADDR_W, DEPTH defaults, and the state encoding constants.
- One natural sub-module: weight_skid_fifo (2-entry, DATA_W+1 wide, with push/pop/count). It is reusable by other layer stream stages.

Test Plan:
- BRAM model preloaded with mem[i]=16'h0100+i; start pulse, w_ready=1 → 28 beats 0x0100..0x011B on consecutive cycles, first beat 2 cycles after start, w_last only on 0x011B, done 1 cycle after the last pop.
- Backpressure: same preload, w_ready toggled 1,0,0,1,… → every value delivered exactly once and in order; data stable while stalled; EN never asserted when fifo_count+inflight=2.
- Load: ld_start, then ld_data=16'hA000+i with ld_valid gaps every 3rd cycle → BRAM holds 0xA000..0xA01B; exactly 28 EN&WE cycles; ld_ready=0 after the 28th; done pulse. A subsequent read sweep returns the same values.
- start and ld_start asserted together → READ only, WE never high. start pulsed again mid-sweep → ignored, beat count stays 28.
- RST asserted asynchronously after the 10th beat → EN/WE/w_valid low before the next edge, no done pulse. New start → sweep restarts from address 0 and delivers 28 beats.
- DEPTH=1 override → a single beat with w_last=1, then done.

Source files
------------

// File: rtl/weight_bram_reader_pkg.sv
// Shared sizing defaults and FSM encoding for the weight BRAM reader and its
// stream stages.
package weight_bram_reader_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 28;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_LOAD  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/weight_bram_reader_skid_fifo.sv
// Two-entry skid FIFO with push/pop/count. A push into a full FIFO is accepted
// only when the head is popped in the same cycle.
module weight_skid_fifo
    import weight_bram_reader_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == 2'd0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && ((count != 2'(SKID_DEPTH)) || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_bram_reader.sv
// Initiator for one weight BRAM port: read sweeps stream weights out over
// valid/ready through a skid FIFO, load sweeps write an incoming stream in.
module weight_bram_reader
    import weight_bram_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              ld_start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DI,
    output logic              EN,
    output logic              WE,
    input  logic [DATA_W-1:0] DO,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] di_next;
    logic              en_next;
    logic              we_next;
    logic              issue;
    logic              issue_last;
    logic              inflight;
    logic              inflight_last;
    logic              accept;
    logic              pop;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic [2:0]        credit_used;

    // A pop in this cycle frees a slot before the new read can land, so it is
    // credited back; without that the stream would only reach half rate.
    assign pop         = w_valid && w_ready;
    assign credit_used = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue       = (state == ST_READ) && (credit_used < 3'(SKID_DEPTH));
    assign issue_last  = issue && (rd_addr == LAST_ADDR);
    assign accept      = (state == ST_LOAD) && ld_valid;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FIN);
    assign ld_ready = (state == ST_LOAD);
    assign w_valid  = !fifo_empty;
    assign w_data   = fifo_head[DATA_W:1];
    assign w_last   = fifo_head[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr_next  = ADDR;
        di_next    = DI;
        en_next    = 1'b0;
        we_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)         state_next = ST_READ;
                else if (ld_start) state_next = ST_LOAD;
            end
            ST_READ: begin
                if (issue) begin
                    en_next   = 1'b1;
                    addr_next = rd_addr;
                end
                if (issue_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight && (fifo_count == {1'b0, pop})) state_next = ST_FIN;
            end
            ST_LOAD: begin
                if (accept) begin
                    en_next   = 1'b1;
                    we_next   = 1'b1;
                    addr_next = wr_addr;
                    di_next   = ld_data;
                    if (wr_addr == LAST_ADDR) state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ADDR          <= '0;
            DI            <= '0;
            EN            <= 1'b0;
            WE            <= 1'b0;
            rd_addr       <= '0;
            wr_addr       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            ADDR          <= addr_next;
            DI            <= di_next;
            EN            <= en_next;
            WE            <= we_next;
            inflight      <= issue;
            inflight_last <= issue_last;
            if (state == ST_IDLE) begin
                rd_addr <= '0;
                wr_addr <= '0;
            end else begin
                if (issue)  rd_addr <= rd_addr + ADDR_W'(1);
                if (accept) wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end

    weight_skid_fifo #(
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (inflight),
        .push_data ({DO, inflight_last}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule
